// File: rtl/pkt_display_pkg.sv
// Shared types and constants for the packet-buffer display block.
// Latency: n/a (types, constants and a combinational glyph function only).
// Backpressure: n/a.
//
// Contents: FSM state enum with its displayed codes, the buffer fill key,
// the per-digit descriptor struct and the hex-to-7-segment decoder.
package pkt_display_pkg;

  // Enum values are the codes shown on digit 3.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [3:0] CODE_IDLE  = 4'd0;
  localparam logic [3:0] CODE_LOAD  = 4'd1;
  localparam logic [3:0] CODE_READY = 4'd2;

  // Buffer entry a holds a[7:0] ^ PATTERN_KEY.
  localparam logic [7:0] PATTERN_KEY = 8'hA5;

  // Segment vector order is {a,b,c,d,e,f,g} = {ca,cb,cc,cd,ce,cf,cg}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One display digit: a nibble, or blank when blank is set.
  typedef struct packed {
    logic       blank;
    logic [3:0] nib;
  } digit_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000; // F
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_mux.sv
// Time-multiplexes eight digit descriptors onto one 7-segment bus.
// Latency: combinational from digit select to an/seg; each digit held REFRESH_DIV cycles.
// Backpressure: none; free-running scan, inputs sampled continuously.
//
// Ports: clk, rst_n (async active-low); digits[7:0] (digit_t per position);
//        an[7:0] one-hot-low anode select; seg[6:0] active-low {a..g}.
module seg7_mux
  import pkt_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  digit_t [7:0] digits,
  output logic   [7:0] an,
  output logic   [6:0] seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [2:0]    digit_sel;
  digit_t        cur;

  // digit_sel is 3 bits, so 7 -> 0 wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_sel   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    cur = digits[digit_sel];
    an  = ~(8'b0000_0001 << digit_sel);
    seg = cur.blank ? SEG_BLANK : hex_to_seg(cur.nib);
  end

endmodule

// File: rtl/pkt_display_wrapper.sv
// Fills a 1024x8 buffer with a keyed pattern on request and shows one entry on 8 digits.
// Latency: button action 3 clk after press; displayed data 1 clk after address change.
// Backpressure: none; buttons are single-shot events, presses during LOAD are dropped.
//
// Ports: clk; BTNC async active-low reset; BTNU load, BTND step (async, active-high);
//        an[7:0] anodes, ca..cg segments, dp decimal point (all active-low).
module pkt_display_wrapper
  import pkt_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int PKT_DEPTH   = 1024
) (
  input  logic       clk,
  input  logic       BTNC,
  input  logic       BTNU,
  input  logic       BTND,
  output logic [7:0] an,
  output logic       ca,
  output logic       cb,
  output logic       cc,
  output logic       cd,
  output logic       ce,
  output logic       cf,
  output logic       cg,
  output logic       dp
);

  localparam int AW = $clog2(PKT_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_DEPTH - 1);

  // Reset asserts immediately with BTNC and releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge BTNC) begin
    if (!BTNC) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two synchronizer flops plus one history flop per button; the edge is a
  // single-cycle pulse however long the button is held.
  logic [2:0] btnu_sync, btnd_sync;
  logic       up_edge, dn_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnu_sync <= '0;
      btnd_sync <= '0;
    end else begin
      btnu_sync <= {btnu_sync[1:0], BTNU};
      btnd_sync <= {btnd_sync[1:0], BTND};
    end
  end
  assign up_edge = btnu_sync[1] & ~btnu_sync[2];
  assign dn_edge = btnd_sync[1] & ~btnd_sync[2];

  state_t          state_q, state_d;
  logic [AW-1:0]   view_addr_q, view_addr_d;
  logic [AW-1:0]   load_addr_q, load_addr_d;
  logic            mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      view_addr_q <= '0;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      view_addr_q <= view_addr_d;
      load_addr_q <= load_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    view_addr_d = view_addr_q;
    load_addr_d = load_addr_q;
    mem_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (up_edge) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          view_addr_d = '0;
        end
      end
      ST_LOAD: begin
        mem_we = 1'b1;
        if (load_addr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          load_addr_d = '0;
          view_addr_d = '0;
        end else begin
          load_addr_d = load_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        // Load has priority when both buttons fire in the same cycle.
        if (up_edge) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          view_addr_d = '0;
        end else if (dn_edge) begin
          view_addr_d = (view_addr_q == LAST_ADDR) ? '0 : view_addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Inferred single-port-write / registered-read RAM; contents are not reset.
  logic [7:0] mem [PKT_DEPTH];
  logic [7:0] rd_dat;

  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr_q] <= load_addr_q[7:0] ^ PATTERN_KEY;
    rd_dat <= mem[view_addr_q];
  end

  // Digit map, left to right: 0, addr[9:8], addr[7:4], addr[3:0], state, blank, data hi, data lo.
  logic [11:0]  addr_ext;
  logic         show_data;
  digit_t [7:0] digits;

  always_comb begin
    addr_ext  = 12'(view_addr_q);
    show_data = (state_q != ST_IDLE);
    digits    = '0;
    digits[7] = '{blank: 1'b0, nib: 4'h0};
    digits[6] = '{blank: 1'b0, nib: addr_ext[11:8]};
    digits[5] = '{blank: 1'b0, nib: addr_ext[7:4]};
    digits[4] = '{blank: 1'b0, nib: addr_ext[3:0]};
    digits[3] = '{blank: 1'b0, nib: 4'(state_q)};
    digits[2] = '{blank: 1'b1, nib: 4'h0};
    digits[1] = '{blank: ~show_data, nib: rd_dat[7:4]};
    digits[0] = '{blank: ~show_data, nib: rd_dat[3:0]};
  end

  logic [6:0] seg;

  seg7_mux #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_seg7_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .digits (digits),
    .an     (an),
    .seg    (seg)
  );

  assign {ca, cb, cc, cd, ce, cf, cg} = seg;
  assign dp = 1'b1;

endmodule

// File: tb/tb_pkt_display_wrapper.sv
module tb_pkt_display_wrapper;

  logic       clk;
  logic       BTNC, BTNU, BTND;
  logic [7:0] an;
  logic       ca, cb, cc, cd, ce, cf, cg, dp;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0 idle, 1 loading, 2 ready; viewed address.
  int m_mode = 0;
  int m_addr = 0;

  pkt_display_wrapper #(
    .REFRESH_DIV(4),
    .PKT_DEPTH  (1024)
  ) dut (
    .clk (clk),
    .BTNC(BTNC),
    .BTNU(BTNU),
    .BTND(BTND),
    .an  (an),
    .ca  (ca),
    .cb  (cb),
    .cc  (cc),
    .cd  (cd),
    .ce  (ce),
    .cf  (cf),
    .cg  (cg),
    .dp  (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Standard lit segments per hex value, active-high, order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] lit_pattern(input int v);
    case (v)
      0: return 7'b1111110;   1: return 7'b0110000;
      2: return 7'b1101101;   3: return 7'b1111001;
      4: return 7'b0110011;   5: return 7'b1011011;
      6: return 7'b1011111;   7: return 7'b1110000;
      8: return 7'b1111111;   9: return 7'b1111011;
      10: return 7'b1110111;  11: return 7'b0011111;
      12: return 7'b1001110;  13: return 7'b0111101;
      14: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // 0..15 = hex glyph, 16 = blank, 99 = not a valid glyph.
  function automatic int decode_glyph(input logic [6:0] seg_low);
    logic [6:0] lit;
    lit = ~seg_low;
    if (lit == 7'b0) return 16;
    for (int v = 0; v < 16; v++)
      if (lit == lit_pattern(v)) return v;
    return 99;
  endfunction

  function automatic int cur_glyph();
    return decode_glyph({ca, cb, cc, cd, ce, cf, cg});
  endfunction

  function automatic int pattern_of(input int addr);
    return (addr & 255) ^ 'hA5;
  endfunction

  // Watch one full scan (8 digits x 4 cycles) and compare every digit.
  task automatic check_display(input string tag, input int mode, input int addr, input int data);
    int         seen[8];
    int         exp[8];
    int         idx;
    bit         bad_an, bad_dp;
    logic [7:0] onehot;
    for (int k = 0; k < 8; k++) seen[k] = -1;
    exp[7] = 0;
    exp[6] = (addr >> 8) & 3;
    exp[5] = (addr >> 4) & 15;
    exp[4] = addr & 15;
    exp[3] = mode;
    exp[2] = 16;
    exp[1] = (mode == 0) ? 16 : ((data >> 4) & 15);
    exp[0] = (mode == 0) ? 16 : (data & 15);
    bad_an = 1'b0;
    bad_dp = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = -1;
      for (int k = 0; k < 8; k++) begin
        onehot = 8'b0000_0001 << k;
        if (an == ~onehot) idx = k;
      end
      if (idx < 0) bad_an = 1'b1;
      else seen[idx] = cur_glyph();
      if (dp !== 1'b1) bad_dp = 1'b1;
    end
    chk({tag, "_an_onehot_bad"}, int'(bad_an), 0);
    chk({tag, "_dp_lit"}, int'(bad_dp), 0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_digit%0d", tag, k), seen[k], exp[k]);
  endtask

  task automatic press(input bit u, input bit d, input int hold, input int gap);
    @(negedge clk);
    BTNU = u;
    BTND = d;
    repeat (hold) @(negedge clk);
    BTNU = 1'b0;
    BTND = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic model_press(input bit u, input bit d);
    if (m_mode == 2) begin
      if (u) begin m_mode = 1; m_addr = 0; end
      else if (d) m_addr = (m_addr + 1) % 1024;
    end else if (m_mode == 0 && u) begin
      m_mode = 1;
      m_addr = 0;
    end
  endtask

  // Long enough for a full 1024-entry load started by the preceding press.
  task automatic wait_load();
    repeat (1100) @(negedge clk);
    if (m_mode == 1) begin m_mode = 2; m_addr = 0; end
  endtask

  typedef struct {
    bit up;
    bit dn;
    int hold;
    bit wait_ld;
    int mode;
    int addr;
    int data;
  } vec_t;

  vec_t vecs[11];
  int   load_cnt;
  int   old_addr;
  bit   found;
  bit   u, d;
  int   r;

  initial begin
    vecs[0]  = '{0, 1, 10, 0, 2, 1, 'hA4};
    vecs[1]  = '{0, 1, 4,  0, 2, 2, 'hA7};
    vecs[2]  = '{0, 1, 1,  0, 2, 3, 'hA6};
    vecs[3]  = '{0, 1, 7,  0, 2, 4, 'hA1};
    vecs[4]  = '{0, 1, 2,  0, 2, 5, 'hA0};
    vecs[5]  = '{1, 0, 3,  0, 1, 0, 'hA5};
    vecs[6]  = '{1, 0, 5,  0, 1, 0, 'hA5};
    vecs[7]  = '{0, 1, 5,  1, 2, 0, 'hA5};
    vecs[8]  = '{1, 1, 4,  0, 1, 0, 'hA5};
    vecs[9]  = '{0, 1, 1,  1, 2, 0, 'hA5};
    vecs[10] = '{0, 1, 6,  0, 2, 1, 'hA4};

    BTNC = 1'b0;
    BTNU = 1'b0;
    BTND = 1'b0;

    // Reset held three cycles: digit 0 selected and blank, dp off.
    repeat (3) @(negedge clk);
    chk("rst_an", int'(an), 'hFE);
    chk("rst_glyph", cur_glyph(), 16);
    chk("rst_dp", int'(dp), 1);
    BTNC = 1'b1;
    @(negedge clk);
    chk("rel_an", int'(an), 'hFE);
    repeat (4) @(negedge clk);
    check_display("reset", 0, 0, 0);

    // Step is ignored in IDLE.
    press(0, 1, 3, 4);
    model_press(0, 1);
    check_display("idle_dn", m_mode, m_addr, pattern_of(m_addr));

    // Load from IDLE: exactly 1024 cycles in LOAD, then READY at 000 / A5.
    load_cnt = 0;
    BTNU = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (i == 3) BTNU = 1'b0;
      if (int'(dut.state_q) == 1) load_cnt++;
      else if (load_cnt > 0) break;
    end
    chk("load_cycles", load_cnt, 1024);
    chk("state_after_load", int'(dut.state_q), 2);
    m_mode = 2;
    m_addr = 0;
    check_display("after_load", 2, 0, 'hA5);

    // Directed vectors: steps, reload from 0x05, presses during LOAD, both at once.
    for (int i = 0; i < 11; i++) begin
      press(vecs[i].up, vecs[i].dn, vecs[i].hold, 4);
      if (vecs[i].wait_ld) repeat (1100) @(negedge clk);
      check_display($sformatf("vec%0d", i), vecs[i].mode, vecs[i].addr, vecs[i].data);
    end
    m_mode = 2;
    m_addr = 1;

    // Read data trails the address by exactly one cycle.
    old_addr = m_addr;
    found = 1'b0;
    BTND = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) BTND = 1'b0;
      if (!found && int'(dut.view_addr_q) != old_addr) begin
        found = 1'b1;
        chk("lat_addr_value", int'(dut.view_addr_q), old_addr + 1);
        chk("lat_same_cycle", int'(dut.rd_dat), pattern_of(old_addr));
        @(negedge clk);
        chk("lat_next_cycle", int'(dut.rd_dat), pattern_of(old_addr + 1));
      end
    end
    chk("lat_addr_changed", int'(found), 1);
    m_addr = old_addr + 1;

    // Reload, then 1023 randomly-shaped steps to 3FF and one more to wrap.
    press(1, 0, 2, 4);
    model_press(1, 0);
    wait_load();
    for (int p = 0; p < 1023; p++) begin
      press(0, 1, $urandom_range(1, 6), $urandom_range(3, 6));
      model_press(0, 1);
      if (p % 256 == 255)
        check_display($sformatf("walk%0d", p), m_mode, m_addr, pattern_of(m_addr));
    end
    check_display("addr_3ff", 2, 'h3FF, 'h5A);
    press(0, 1, 4, 4);
    model_press(0, 1);
    check_display("wrap_000", 2, 0, 'hA5);

    // Random mix of steps, loads and simultaneous presses against the model.
    for (int e = 0; e < 24; e++) begin
      r = $urandom_range(0, 9);
      u = (r <= 1);
      d = (r >= 1);
      press(u, d, $urandom_range(1, 12), $urandom_range(3, 6));
      model_press(u, d);
      if (u) wait_load();
      check_display($sformatf("rnd%0d", e), m_mode, m_addr, pattern_of(m_addr));
    end

    // Reset in the middle of a load aborts it straight to IDLE.
    press(1, 0, 3, 0);
    repeat (100) @(negedge clk);
    BTNC = 1'b0;
    #1;
    chk("abort_an", int'(an), 'hFE);
    chk("abort_glyph", cur_glyph(), 16);
    chk("abort_state", int'(dut.state_q), 0);
    repeat (3) @(negedge clk);
    BTNC = 1'b1;
    m_mode = 0;
    m_addr = 0;
    repeat (4) @(negedge clk);
    check_display("after_abort", m_mode, m_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
